xy_poll_master: RTL and testbench
=================================

Name: xy_poll_master

Overview:
- Avalon-MM master that periodically reads the DEV_ID, X and Y registers of the ultrasonic xy location slave.
- Checks the device ID, then packs each X/Y pair into a sample and buffers it in a small FIFO.
- Hands samples to a downstream consumer (display or UART formatter) over a valid/ready stream.
- Sits in the fabric beside the location slave, so samples are produced without NIOS polling.

Parameters:
- POLL_PERIOD, 50000, cycles between poll-sequence starts (1 ms at 50 MHz); legal range 8 and up.
- FIFO_DEPTH, 8, sample FIFO entries; power of two, 2 to 64.
- EXP_DEV_ID, 32'hECE45318, expected DEV_ID register value.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  1 = polling runs; 0 = finish current sequence, then idle
- master_address  out  5  register address; DEV_ID=0, X=1, Y=2
- master_read  out  1  Avalon read strobe
- master_readdata  in  32  read data, valid in the cycle master_read=1 and master_waitrequest=0
- master_waitrequest  in  1  slave stall
- sample_valid  out  1  FIFO not empty
- sample_ready  in  1  consumer accepts the head sample
- sample_x  out  32  head sample X
- sample_y  out  16  head sample Y, taken from readdata[15:0]
- id_error  out  1  sticky: DEV_ID mismatch seen
- overflow_cnt  out  16  saturating count of samples dropped because the FIFO was full

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values:
  - master_read=0, master_address=0, sample_valid=0, id_error=0, overflow_cnt=0.
  - Period counter=0, FIFO empty, state=IDLE.
- Period counter:
  - Free-runs 0..POLL_PERIOD-1 and wraps.
  - tick = (counter == POLL_PERIOD-1).
  - Counts regardless of state.
- FSM states: IDLE, RD_ID, RD_X, RD_Y, PUSH.
  - IDLE: on tick and enable=1, go to RD_ID. A tick while not IDLE is ignored, with no queuing.
  - RD_ID / RD_X / RD_Y:
    - master_read=1, address 0/1/2, held stable while waitrequest=1.
    - On the accept cycle (read=1, waitrequest=0), capture readdata and advance the next cycle.
    - Back-to-back reads are allowed: the next state asserts read immediately.
    - With zero waitrequest, RD_ID→RD_X→RD_Y→PUSH takes 3 cycles.
  - RD_ID mismatch: set id_error, return to IDLE, no sample pushed.
  - RD_ID match: continue to RD_X.
  - PUSH:
    - One cycle; write {x, y} to the FIFO if not full.
    - If full: drop the sample and increment overflow_cnt, saturating at 16'hFFFF.
    - Then go to IDLE.
- enable deasserted mid-sequence: the sequence completes normally; no new sequence starts.
- FIFO:
  - Show-ahead; sample_x/sample_y reflect the head whenever sample_valid=1.
  - Pop on sample_valid & sample_ready.
  - Push and pop in the same cycle are both honoured, including when full: a pop frees a slot, so that push is not dropped.
  - Occupancy pointers wrap modulo FIFO_DEPTH; full = count==FIFO_DEPTH.
  - Latency from the Y accept cycle to sample_valid rising on an empty FIFO: 2 cycles (PUSH write, then registered valid).
- Reset mid-read: master_read drops the cycle after reset is sampled; the FIFO is flushed.
- Width rule: sample_y = Y readdata[15:0]; upper bits are ignored.

Optional Feature:
- Macro: XY_DEDUP_EN.
- Defined:
  - PUSH compares {x, y} with the last pushed sample and skips the push on an exact match.
  - A skipped push does not count as overflow.
  - The last-pushed register resets to 48'h0, so a first sample of 0/0 is suppressed.
- Undefined: every valid sequence pushes.

Decomposition:
- Package xy_pkg:
  - localparams DEV_ID_ADDR=0, X_ADDR=1, Y_ADDR=2.
  - Default EXP_DEV_ID.
  - Enum poll_state_t {IDLE, RD_ID, RD_X, RD_Y, PUSH}.
  - Struct xy_sample_t {logic [31:0] x; logic [15:0] y;}.
- Sub-module xy_sample_fifo: parameterised FIFO_DEPTH; push/full/pop/empty/count.
- FSM, period counter and dedup logic stay in the top.

Test Plan:
- Zero-wait slave returning ID=ECE45318, X=32'h00001234, Y=32'hABCD0056, POLL_PERIOD=8, sample_ready=1:
  - Reads at addresses 0,1,2 on consecutive cycles.
  - One sample x=1234, y=0056 per 8 cycles.
  - id_error=0.
- Waitrequest held 3 cycles on the X read: address=1 and read=1 are stable for 4 cycles, then the sequence completes with the correct sample.
- Slave ID=32'hDEADBEEF: id_error=1 after the first sequence, no X/Y reads, sample_valid stays 0, and id_error persists until reset.
- FIFO_DEPTH=4, sample_ready=0, 6 ticks:
  - 4 samples are held and overflow_cnt=2.
  - Raise ready: 4 pops in FIFO order.
  - With pop and push in the same cycle when full, overflow does not increment.
- Assert reset during RD_X wait: the next cycle master_read=0, sample_valid=0, overflow_cnt=0; polling resumes on the next tick after reset is released.
- XY_DEDUP_EN defined with identical X/Y on 3 ticks, then Y changed: exactly 2 samples pushed. Macro undefined: 4 samples pushed.

Source files
------------

// File: rtl/xy_pkg.sv
// Shared addresses, types and defaults for the xy location poll master.
package xy_pkg;

  localparam logic [4:0]  DEV_ID_ADDR    = 5'd0;
  localparam logic [4:0]  X_ADDR         = 5'd1;
  localparam logic [4:0]  Y_ADDR         = 5'd2;
  localparam logic [31:0] DEF_EXP_DEV_ID = 32'hECE45318;

  typedef enum logic [2:0] {IDLE, RD_ID, RD_X, RD_Y, PUSH} poll_state_t;

  typedef struct packed {
    logic [31:0] x;
    logic [15:0] y;
  } xy_sample_t;

endpackage

// File: rtl/xy_sample_fifo.sv
// Show-ahead sample FIFO; a pop in the same cycle lets a push into a full FIFO.
module xy_sample_fifo
  import xy_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  xy_sample_t                  wdata,
  output logic                        full,
  input  logic                        pop,
  output xy_sample_t                  rdata,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  xy_sample_t      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic            wr_en, rd_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == (PtrW + 1)'(FIFO_DEPTH));
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (wr_en && !rd_en) begin
        count_q <= count_q + (PtrW + 1)'(1);
      end else if (!wr_en && rd_en) begin
        count_q <= count_q - (PtrW + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/xy_poll_master.sv
// Periodic Avalon-MM poller of the xy location slave, feeding a sample stream.
// Optional XY_DEDUP_EN: skip pushing a sample identical to the last pushed one.
module xy_poll_master
  import xy_pkg::*;
#(
  parameter int unsigned POLL_PERIOD = 50000,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [31:0] EXP_DEV_ID  = DEF_EXP_DEV_ID
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [4:0]  master_address,
  output logic        master_read,
  input  logic [31:0] master_readdata,
  input  logic        master_waitrequest,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic [31:0] sample_x,
  output logic [15:0] sample_y,
  output logic        id_error,
  output logic [15:0] overflow_cnt
);

  localparam int unsigned CntW = $clog2(POLL_PERIOD);

  poll_state_t   state_q, state_d;
  logic [CntW-1:0] cnt_q;
  logic          tick;
  logic [31:0]   x_q;
  logic [15:0]   y_q;
  logic          id_error_q;
  logic [15:0]   ovf_q;
  logic          id_err_set, cap_x, cap_y, push_req;
  logic          dup, push, push_ok, pop_en;
  logic          fifo_full, fifo_empty;
  xy_sample_t    fifo_rdata;
  logic [$clog2(FIFO_DEPTH):0] unused_fifo_count;

  assign tick = (cnt_q == CntW'(POLL_PERIOD - 1));

  always_ff @(posedge clk) begin
    if (reset || tick) cnt_q <= '0;
    else               cnt_q <= cnt_q + CntW'(1);
  end

  always_comb begin
    state_d        = state_q;
    master_read    = 1'b0;
    master_address = DEV_ID_ADDR;
    id_err_set     = 1'b0;
    cap_x          = 1'b0;
    cap_y          = 1'b0;
    push_req       = 1'b0;
    unique case (state_q)
      IDLE: if (tick && enable) state_d = RD_ID;
      RD_ID: begin
        master_read = 1'b1;
        if (!master_waitrequest) begin
          if (master_readdata == EXP_DEV_ID) begin
            state_d = RD_X;
          end else begin
            id_err_set = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      RD_X: begin
        master_read    = 1'b1;
        master_address = X_ADDR;
        if (!master_waitrequest) begin
          cap_x   = 1'b1;
          state_d = RD_Y;
        end
      end
      RD_Y: begin
        master_read    = 1'b1;
        master_address = Y_ADDR;
        if (!master_waitrequest) begin
          cap_y   = 1'b1;
          state_d = PUSH;
        end
      end
      PUSH: begin
        push_req = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop_en  = sample_ready & ~fifo_empty;
  assign push    = push_req & ~dup;
  assign push_ok = push & (~fifo_full | pop_en);

`ifdef XY_DEDUP_EN
  logic [47:0] last_q;
  assign dup = ({x_q, y_q} == last_q);
  always_ff @(posedge clk) begin
    if (reset)        last_q <= 48'h0;
    else if (push_ok) last_q <= {x_q, y_q};
  end
`else
  assign dup = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      id_error_q <= 1'b0;
      ovf_q      <= '0;
    end else begin
      state_q <= state_d;
      if (cap_x)      x_q        <= master_readdata;
      if (cap_y)      y_q        <= master_readdata[15:0];
      if (id_err_set) id_error_q <= 1'b1;
      // Dropped only when full with no simultaneous pop freeing a slot.
      if (push && !push_ok && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 16'd1;
    end
  end

  xy_sample_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .wdata('{x: x_q, y: y_q}),
    .full (fifo_full),
    .pop  (sample_ready),
    .rdata(fifo_rdata),
    .empty(fifo_empty),
    .count(unused_fifo_count)
  );

  assign sample_valid = ~fifo_empty;
  assign sample_x     = fifo_rdata.x;
  assign sample_y     = fifo_rdata.y;
  assign id_error     = id_error_q;
  assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_xy_poll_master.sv
// Directed bench for xy_poll_master with a small register-slave model.
module tb_xy_poll_master;

`ifdef XY_DEDUP_EN
  localparam int ExpDedup = 2;
`else
  localparam int ExpDedup = 4;
`endif

  logic        clk, reset, enable;
  logic [4:0]  master_address;
  logic        master_read;
  logic [31:0] master_readdata;
  logic        master_waitrequest;
  logic        sample_valid, sample_ready;
  logic [31:0] sample_x;
  logic [15:0] sample_y;
  logic        id_error;
  logic [15:0] overflow_cnt;

  logic [31:0] id_val, x_val, y_val;
  logic        wait_x;
  int          n_checks, n_fail;

  xy_poll_master #(
    .POLL_PERIOD(8),
    .FIFO_DEPTH (4),
    .EXP_DEV_ID (32'hECE45318)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .enable            (enable),
    .master_address    (master_address),
    .master_read       (master_read),
    .master_readdata   (master_readdata),
    .master_waitrequest(master_waitrequest),
    .sample_valid      (sample_valid),
    .sample_ready      (sample_ready),
    .sample_x          (sample_x),
    .sample_y          (sample_y),
    .id_error          (id_error),
    .overflow_cnt      (overflow_cnt)
  );

  assign master_readdata = (master_address == 5'd0) ? id_val :
                           (master_address == 5'd1) ? x_val  :
                           (master_address == 5'd2) ? y_val  : 32'h0;
  assign master_waitrequest = wait_x && master_read && (master_address == 5'd1);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until the given read is on the bus; returns the number of edges taken.
  task automatic wait_read(input logic [4:0] addr, input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!(master_read && master_address == addr) && n < budget);
    if (!(master_read && master_address == addr)) check("wait_read_timeout", 0, 1);
  endtask

  int n, bad, seen;
  logic [31:0] exp_x [4];
  logic [15:0] exp_y [4];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1; enable = 1'b0; sample_ready = 1'b0; wait_x = 1'b0;
    id_val = 32'hECE45318; x_val = 32'h0000_1234; y_val = 32'hABCD_0056;
    repeat (3) step();
    check("rst_read", master_read, 0);
    check("rst_addr", master_address, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_id_error", id_error, 0);
    check("rst_ovf", overflow_cnt, 0);

    // Basic zero-wait sequence and period.
    reset = 1'b0; enable = 1'b1; sample_ready = 1'b1;
    wait_read(5'd0, 20, n);
    check("first_tick_latency", n, 8);
    step(); check("rd_x", {master_read, master_address}, {1'b1, 5'd1});
    step(); check("rd_y", {master_read, master_address}, {1'b1, 5'd2});
    step(); check("push_no_read", master_read, 0);
    step();
    check("s1_valid", sample_valid, 1);
    check("s1_x", sample_x, 32'h1234);
    check("s1_y", sample_y, 16'h0056);
    step(); check("s1_popped", sample_valid, 0);
    wait_read(5'd0, 20, n);
    check("period", n, 3);
    check("id_ok", id_error, 0);

    // Waitrequest for three cycles on the X read.
    x_val = 32'h0000_BEEF; y_val = 32'h1111_2222; wait_x = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("x_stall_stable", {master_read, master_address}, {1'b1, 5'd1});
      if (i == 3) wait_x = 1'b0;
    end
    step(); check("stall_rd_y", {master_read, master_address}, {1'b1, 5'd2});
    step();
    step();
    check("s2_valid", sample_valid, 1);
    check("s2_x", sample_x, 32'h0000_BEEF);
    check("s2_y", sample_y, 16'h2222);
    step();
    check("s2_popped", sample_valid, 0);

    // Overflow: six sequences into a 4-deep FIFO with no consumer.
    sample_ready = 1'b0;
    check("t3_rdid", {master_read, master_address}, {1'b1, 5'd0});
    for (int i = 0; i < 6; i++) begin
      if (i > 0) wait_read(5'd0, 20, n);
      x_val = 32'h100 + i;
      y_val = i;
    end
    repeat (4) step();
    check("ovf_cnt", overflow_cnt, 2);
    check("full_head_x", sample_x, 32'h100);
    check("full_head_y", sample_y, 16'h0);
    x_val = 32'h106; y_val = 32'h6;
    wait_read(5'd0, 20, n);
    repeat (3) step();
    sample_ready = 1'b1;
    step();
    sample_ready = 1'b0;
    check("simul_no_ovf", overflow_cnt, 2);
    enable = 1'b0; sample_ready = 1'b1;
    exp_x[0] = 32'h101; exp_x[1] = 32'h102; exp_x[2] = 32'h103; exp_x[3] = 32'h106;
    exp_y[0] = 16'h1;   exp_y[1] = 16'h2;   exp_y[2] = 16'h3;   exp_y[3] = 16'h6;
    for (int k = 0; k < 4; k++) begin
      check("drain_valid", sample_valid, 1);
      check("drain_x", sample_x, exp_x[k]);
      check("drain_y", sample_y, exp_y[k]);
      step();
    end
    check("drain_empty", sample_valid, 0);

    // Device ID mismatch.
    id_val = 32'hDEADBEEF; enable = 1'b1;
    wait_read(5'd0, 20, n);
    step();
    check("id_bad_no_x", master_read, 0);
    check("id_error_set", id_error, 1);
    bad = 0; seen = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (master_read && master_address != 5'd0) bad++;
      if (sample_valid) seen++;
    end
    check("id_bad_xy_reads", bad, 0);
    check("id_bad_no_sample", seen, 0);
    check("id_error_sticky", id_error, 1);

    // Reset while stalled in RD_X with a sample queued.
    id_val = 32'hECE45318; x_val = 32'h0000_1234; y_val = 32'hABCD_0056;
    sample_ready = 1'b0;
    wait_read(5'd0, 20, n);
    repeat (4) step();
    check("t5_pre_valid", sample_valid, 1);
    wait_x = 1'b1;
    wait_read(5'd1, 20, n);
    step();
    reset = 1'b1;
    step();
    check("rst_mid_read", master_read, 0);
    check("rst_mid_valid", sample_valid, 0);
    check("rst_mid_ovf", overflow_cnt, 0);
    check("rst_mid_id_error", id_error, 0);
    reset = 1'b0; wait_x = 1'b0; sample_ready = 1'b1;
    wait_read(5'd0, 20, n);
    check("resume_latency", n, 8);
    repeat (4) step();
    check("resume_x", sample_x, 32'h1234);
    step();

    // Repeated samples, then a changed Y; enable dropped mid last sequence.
    seen = 0;
    for (int s = 0; s < 4; s++) begin
      x_val = 32'h5;
      y_val = (s == 3) ? 32'h8 : 32'h7;
      wait_read(5'd0, 20, n);
      if (s == 3) enable = 1'b0;
      for (int k = 0; k < 5; k++) begin
        step();
        if (sample_valid) seen++;
      end
    end
    check("dedup_count", seen, ExpDedup);
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (master_read) bad++;
    end
    check("disabled_no_reads", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
